// File: rtl/throw_ctl.sv
// Turn-based throw sequencer: aim -> flight -> hit/miss -> turn switch.
// Optional wind input enabled by defining THROW_WIND_EN.
module throw_ctl #(
  parameter int SCREEN_W  = 800,
  parameter int SCREEN_H  = 600,
  parameter int GROUND_Y  = 550,
  parameter int PROJ_Y0   = 500,
  parameter int CAT_X     = 100,
  parameter int DOG_X     = 650,
  parameter int TARGET_W  = 64,
  parameter int TARGET_H  = 64,
  parameter int VX        = 4,
  parameter int GRAVITY   = 1,
  parameter int POWER_MAX = 63
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vsync,
  input  logic              mouse_left,
`ifdef THROW_WIND_EN
  input  logic signed [2:0] wind,
`endif
  output logic [11:0]       xpos,
  output logic [11:0]       ypos,
  output logic              proj_en,
  output logic              turn,
  output logic [5:0]        power,
  output logic              hit,
  output logic [3:0]        cat_score,
  output logic [3:0]        dog_score,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_AIM, S_FLIGHT, S_HIT, S_MISS, S_SWITCH
  } state_t;

  localparam logic signed [12:0] XMAX = 13'(SCREEN_W - 1);
  localparam logic signed [12:0] YMAX = 13'(SCREEN_H - 1);
  localparam logic signed [12:0] GY   = 13'(GROUND_Y);
  localparam logic signed [12:0] Y0   = 13'(PROJ_Y0);
  localparam logic signed [12:0] CX   = 13'(CAT_X);
  localparam logic signed [12:0] DX   = 13'(DOG_X);
  localparam logic signed [12:0] BTOP = 13'(GROUND_Y - TARGET_H);
  localparam logic signed [12:0] BW   = 13'(TARGET_W - 1);
  localparam logic [5:0]         PMAX = 6'(POWER_MAX);
  localparam logic signed [8:0]  GRV  = 9'(GRAVITY);

  state_t            state_q;
  logic              turn_q, proj_en_q, hit_q;
  logic [5:0]        power_q;
  logic [3:0]        cat_q, dog_q;
  logic [11:0]       xpos_q, ypos_q;
  logic signed [12:0] x_q, y_q;
  logic signed [7:0] vx_q, vy_q;

  logic ml_meta_q, ml_sync_q, ml_prev_q;
  logic ml_rise_q, ml_fall_q;
  logic vs_prev_q, tick_q;
  logic [1:0] arm_cnt_q;
  logic armed_q;

  logic signed [12:0] nx, ny, x_launch, opp_x;
  logic signed [8:0]  vy_sum;
  logic signed [7:0]  vy_n, vx_l;
  logic               in_box, out_miss;

  function automatic logic [11:0] clamp(
    input logic signed [12:0] v,
    input logic signed [12:0] hi
  );
    if (v < 13'sd0) return 12'd0;
    else if (v > hi) return hi[11:0];
    else return v[11:0];
  endfunction

  assign x_launch = turn_q ? DX : CX;
  assign opp_x    = turn_q ? CX : DX;
  assign nx       = x_q + {{5{vx_q[7]}}, vx_q};
  assign ny       = y_q + {{5{vy_q[7]}}, vy_q};
  assign vy_sum   = {vy_q[7], vy_q} + GRV;
  assign vy_n     = (vy_sum > 9'sd127) ? 8'sd127 : vy_sum[7:0];
  assign in_box   = (nx >= opp_x) && (nx <= opp_x + BW) &&
                    (ny >= BTOP) && (ny <= GY - 13'sd1);
  assign out_miss = (ny >= GY) || (nx < 13'sd0) || (nx > XMAX);

  // launch velocity: fixed speed toward the opponent, plus optional wind
  always_comb begin
    vx_l = turn_q ? 8'(-VX) : 8'(VX);
`ifdef THROW_WIND_EN
    vx_l = vx_l + {{5{wind[2]}}, wind};
`endif
  end

  // button sync + edge detect; rises only count once the button was seen low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ml_meta_q <= 1'b0;
      ml_sync_q <= 1'b0;
      ml_prev_q <= 1'b0;
      ml_rise_q <= 1'b0;
      ml_fall_q <= 1'b0;
      vs_prev_q <= 1'b0;
      tick_q    <= 1'b0;
      arm_cnt_q <= 2'd0;
      armed_q   <= 1'b0;
    end else begin
      ml_meta_q <= mouse_left;
      ml_sync_q <= ml_meta_q;
      ml_prev_q <= ml_sync_q;
      ml_rise_q <= armed_q & ml_sync_q & ~ml_prev_q;
      ml_fall_q <= ml_prev_q & ~ml_sync_q;
      vs_prev_q <= vsync;
      tick_q    <= vsync & ~vs_prev_q;
      if (arm_cnt_q != 2'd2) arm_cnt_q <= arm_cnt_q + 2'd1;
      if (arm_cnt_q == 2'd2 && !ml_sync_q) armed_q <= 1'b1;
    end
  end

  // game sequencer with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      turn_q    <= 1'b0;
      x_q       <= CX;
      y_q       <= Y0;
      vx_q      <= 8'sd0;
      vy_q      <= 8'sd0;
      xpos_q    <= CX[11:0];
      ypos_q    <= Y0[11:0];
      proj_en_q <= 1'b0;
      hit_q     <= 1'b0;
      power_q   <= 6'd0;
      cat_q     <= 4'd0;
      dog_q     <= 4'd0;
    end else begin
      hit_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          proj_en_q <= 1'b0;
          x_q       <= x_launch;
          y_q       <= Y0;
          xpos_q    <= x_launch[11:0];
          ypos_q    <= Y0[11:0];
          if (ml_rise_q) begin
            state_q <= S_AIM;
            power_q <= 6'd0;
          end
        end
        S_AIM: begin
          if (ml_fall_q) begin
            state_q   <= S_FLIGHT;
            vx_q      <= vx_l;
            vy_q      <= -$signed({2'b00, power_q});
            proj_en_q <= 1'b1;
          end else if (tick_q && ml_sync_q && power_q != PMAX) begin
            power_q <= power_q + 6'd1;
          end
        end
        S_FLIGHT: begin
          if (tick_q) begin
            x_q    <= nx;
            y_q    <= ny;
            vy_q   <= vy_n;
            xpos_q <= clamp(nx, XMAX);
            ypos_q <= clamp(ny, YMAX);
            if (in_box) begin
              state_q <= S_HIT;
              hit_q   <= 1'b1;
            end else if (out_miss) begin
              state_q <= S_MISS;
            end
          end
        end
        S_HIT: begin
          if (turn_q) begin
            if (dog_q != 4'd15) dog_q <= dog_q + 4'd1;
          end else begin
            if (cat_q != 4'd15) cat_q <= cat_q + 4'd1;
          end
          proj_en_q <= 1'b0;
          state_q   <= S_SWITCH;
        end
        S_MISS: begin
          proj_en_q <= 1'b0;
          state_q   <= S_SWITCH;
        end
        S_SWITCH: begin
          proj_en_q <= 1'b0;
          if (tick_q) begin
            turn_q  <= ~turn_q;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign xpos      = xpos_q;
  assign ypos      = ypos_q;
  assign proj_en   = proj_en_q;
  assign turn      = turn_q;
  assign power     = power_q;
  assign hit       = hit_q;
  assign cat_score = cat_q;
  assign dog_score = dog_q;
  assign busy      = (state_q != S_IDLE);

endmodule
